// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, clock deglitch filter, frame FSM and FWFT scan-code FIFO.
// Optional build macro PS2_PREFIX_DECODE_EN folds E0/F0 prefixes into the ext/brk bits of the next code.
module ps2_rx_fifo #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2c,
    input  logic                          ps2d,
    input  logic                          rd_en,
    output logic [9:0]                    rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CHECK
    } state_t;

    logic [SYNC_STAGES-1:0] c_sync, d_sync;
    logic [FILTER_LEN-1:0]  c_hist, d_hist;
    logic                   c_filt;
    logic                   fall_edge;
    logic                   edge_bit;

    state_t                 state;
    logic [3:0]             bit_cnt;
    logic [TW-1:0]          to_cnt;
    logic [9:0]             frame;

    logic [9:0]             mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;

    logic                   frame_good;
    logic [7:0]             code;
    logic                   pop;
    logic                   push_req;
    logic [9:0]             push_word;
    logic                   drop;

`ifdef PS2_PREFIX_DECODE_EN
    logic                   ext_pend, brk_pend;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_sync <= '1;
            d_sync <= '1;
        end else begin
            c_sync[0] <= ps2c;
            d_sync[0] <= ps2d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                c_sync[i] <= c_sync[i-1];
                d_sync[i] <= d_sync[i-1];
            end
        end
    end

    // Data history runs alongside the clock history so the sampled bit lines up
    // with the first low clock sample of the qualifying window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_hist    <= '1;
            d_hist    <= '1;
            c_filt    <= 1'b1;
            fall_edge <= 1'b0;
            edge_bit  <= 1'b0;
        end else begin
            c_hist[0] <= c_sync[SYNC_STAGES-1];
            d_hist[0] <= d_sync[SYNC_STAGES-1];
            for (int i = 1; i < FILTER_LEN; i++) begin
                c_hist[i] <= c_hist[i-1];
                d_hist[i] <= d_hist[i-1];
            end
            fall_edge <= 1'b0;
            if (c_filt && (c_hist == '0)) begin
                c_filt    <= 1'b0;
                fall_edge <= 1'b1;
                edge_bit  <= d_hist[FILTER_LEN-1];
            end else if (!c_filt && (&c_hist)) begin
                c_filt <= 1'b1;
            end
        end
    end

    assign code       = frame[7:0];
    assign frame_good = (^frame[8:0]) && frame[9];
    assign empty      = (count == '0);
    assign full       = (count == CW'(FIFO_DEPTH));
    assign pop        = rd_en && !empty;
    assign drop       = push_req && full && !pop;
    assign rd_data    = empty ? 10'd0 : mem[rd_ptr];

    always_comb begin
        push_req  = 1'b0;
        push_word = '0;
        if (state == CHECK && frame_good) begin
`ifdef PS2_PREFIX_DECODE_EN
            if (code != 8'hE0 && code != 8'hF0) begin
                push_req  = 1'b1;
                push_word = {ext_pend, brk_pend, code};
            end
`else
            push_req  = 1'b1;
            push_word = {2'b00, code};
`endif
        end
    end

    // Frame bits shift in from the top, so after ten edges frame[0] holds data bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            frame     <= '0;
            frame_err <= 1'b0;
`ifdef PS2_PREFIX_DECODE_EN
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (fall_edge) begin
                        if (!edge_bit) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
`ifdef PS2_PREFIX_DECODE_EN
                            ext_pend  <= 1'b0;
                            brk_pend  <= 1'b0;
`endif
                        end
                    end
                end
                DATA: begin
                    if (fall_edge) begin
                        to_cnt <= '0;
                        frame  <= {edge_bit, frame[9:1]};
                        if (bit_cnt == 4'd9) begin
                            state <= CHECK;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        to_cnt    <= '0;
                        state     <= IDLE;
                        frame_err <= 1'b1;
`ifdef PS2_PREFIX_DECODE_EN
                        ext_pend  <= 1'b0;
                        brk_pend  <= 1'b0;
`endif
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (!frame_good) begin
                        frame_err <= 1'b1;
`ifdef PS2_PREFIX_DECODE_EN
                        ext_pend  <= 1'b0;
                        brk_pend  <= 1'b0;
                    end else if (code == 8'hE0) begin
                        ext_pend <= 1'b1;
                    end else if (code == 8'hF0) begin
                        brk_pend <= 1'b1;
                    end else begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_req && !drop) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= drop;
            if (push_req && !drop) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_req && !drop && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !(push_req && !drop)) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
